// File: rtl/econet_tx.sv
// Econet/ADLC-compatible line transmitter.
// Frames bytes from a one-byte valid/ready holding register onto the serial
// line: opening 0x7E flag(s), LSB-first data with zero-bit stuffing, closing
// flag(s), then idle 1s. An empty holding register mid-frame turns into an
// abort (a run of 1s). Frame start is deferred while the receiver reports the
// line busy and until the inter-frame idle gap has elapsed.
// All state changes on the falling edge of the line clock so the line is
// stable before the receiving side samples on the rising edge.
module econet_tx #(
  parameter int LEAD_FLAGS  = 1,
  parameter int TRAIL_FLAGS = 1,
  parameter int ABORT_BITS  = 8,
  parameter int IDLE_BITS   = 15
) (
  input  logic       econet_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       line_busy,
  output logic       econet_data_out,
  output logic       tx_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int GAP_W = $clog2(IDLE_BITS + 1);
  localparam int ABT_W = $clog2(ABORT_BITS + 1);

  localparam logic [7:0]       FLAG      = 8'h7E;
  localparam logic [2:0]       LEAD_LAST = 3'(LEAD_FLAGS - 1);
  localparam logic [2:0]       TRAIL_N   = 3'(TRAIL_FLAGS);
  localparam logic [GAP_W-1:0] GAP_FULL  = GAP_W'(IDLE_BITS);
  localparam logic [ABT_W-1:0] ABORT_N   = ABT_W'(ABORT_BITS);
  localparam logic [ABT_W-1:0] ABORT_Z   = {ABT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_DATA  = 3'd2,
    S_TRAIL = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t           state_q;
  logic [7:0]       hold_data_q;
  logic             hold_last_q;
  logic             hold_full_q;
  logic [7:0]       shift_q;
  logic             shift_last_q;
  logic [2:0]       bit_cnt_q;
  logic [2:0]       flag_cnt_q;
  logic [2:0]       ones_q;
  logic [GAP_W-1:0] gap_q;
  logic [ABT_W-1:0] abort_cnt_q;
  logic             stuff_q;
  logic             data_out_q;
  logic             en_q;
  logic             done_q;
  logic             under_q;

  logic             accept_s;
  logic             load_s;
  logic [2:0]       ones_d;

  // Handshake, shift-register reload and next ones-run length for a data bit.
  always_comb begin
    accept_s = tx_valid && !hold_full_q;
    load_s   = 1'b0;
    ones_d   = shift_q[0] ? (ones_q + 3'd1) : 3'd0;
    if (state_q == S_LEAD) begin
      load_s = (bit_cnt_q == 3'd7) && (flag_cnt_q == LEAD_LAST);
    end else if (state_q == S_DATA) begin
      load_s = (ones_q != 3'd5) && (bit_cnt_q == 3'd7) && !shift_last_q && hold_full_q;
    end else begin
      load_s = 1'b0;
    end
  end

  // Holding register: filled by the handshake, emptied when the shifter loads.
  always_ff @(negedge econet_clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
    end else if (accept_s) begin
      hold_full_q <= 1'b1;
      hold_data_q <= tx_data;
      hold_last_q <= tx_last;
    end else if (load_s) begin
      hold_full_q <= 1'b0;
    end
  end

  // Framing state machine with registered line outputs.
  always_ff @(negedge econet_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_out_q   <= 1'b1;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      under_q      <= 1'b0;
      ones_q       <= 3'd0;
      gap_q        <= GAP_FULL;
      bit_cnt_q    <= 3'd0;
      flag_cnt_q   <= 3'd0;
      abort_cnt_q  <= ABORT_Z;
      stuff_q      <= 1'b0;
      shift_q      <= 8'h00;
      shift_last_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      under_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          data_out_q <= 1'b1;
          en_q       <= 1'b0;
          if (gap_q != GAP_FULL) begin
            gap_q <= gap_q + 1'b1;
          end
          if (hold_full_q && (gap_q == GAP_FULL) && !line_busy) begin
            // Start edge already carries bit 0 of the first opening flag.
            data_out_q <= FLAG[0];
            en_q       <= 1'b1;
            bit_cnt_q  <= 3'd1;
            flag_cnt_q <= 3'd0;
            state_q    <= S_LEAD;
          end
        end
        S_LEAD: begin
          data_out_q <= FLAG[bit_cnt_q];
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (flag_cnt_q == LEAD_LAST) begin
              shift_q      <= hold_data_q;
              shift_last_q <= hold_last_q;
              ones_q       <= 3'd0;
              state_q      <= S_DATA;
            end else begin
              flag_cnt_q <= flag_cnt_q + 3'd1;
            end
          end
        end
        S_DATA: begin
          if (ones_q == 3'd5) begin
            // Stuffed zero; the shifter holds its position.
            data_out_q <= 1'b0;
            ones_q     <= 3'd0;
          end else begin
            data_out_q <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_last_q) begin
                flag_cnt_q <= 3'd0;
                stuff_q    <= (ones_d == 3'd5);
                state_q    <= S_TRAIL;
              end else if (hold_full_q) begin
                shift_q      <= hold_data_q;
                shift_last_q <= hold_last_q;
              end else begin
                abort_cnt_q <= ABORT_Z;
                state_q     <= S_ABORT;
              end
            end
          end
        end
        S_TRAIL: begin
          if (flag_cnt_q == TRAIL_N) begin
            data_out_q <= 1'b1;
            en_q       <= 1'b0;
            done_q     <= 1'b1;
            gap_q      <= {GAP_W{1'b0}};
            state_q    <= S_IDLE;
          end else if (stuff_q) begin
            // Five 1s ended the data: break the run before the flag.
            data_out_q <= 1'b0;
            stuff_q    <= 1'b0;
          end else begin
            data_out_q <= FLAG[bit_cnt_q];
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              flag_cnt_q <= flag_cnt_q + 3'd1;
            end
          end
        end
        S_ABORT: begin
          data_out_q <= 1'b1;
          if (abort_cnt_q == ABORT_N) begin
            en_q    <= 1'b0;
            gap_q   <= {GAP_W{1'b0}};
            state_q <= S_IDLE;
          end else begin
            en_q        <= 1'b1;
            under_q     <= (abort_cnt_q == ABORT_Z);
            abort_cnt_q <= abort_cnt_q + 1'b1;
          end
        end
        default: begin
          data_out_q <= 1'b1;
          en_q       <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready        = !hold_full_q;
  assign tx_busy         = (state_q != S_IDLE) || hold_full_q;
  assign econet_data_out = data_out_q;
  assign tx_en           = en_q;
  assign tx_done         = done_q;
  assign tx_underrun     = under_q;

endmodule

// File: tb/tb_econet_tx.sv
// Directed bench for econet_tx: frames captured bit-by-bit while tx_en is
// high and compared against hand-written expected line sequences.
module tb_econet_tx;

  logic       econet_clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       line_busy;
  logic       econet_data_out;
  logic       tx_en;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  int errors = 0;
  int checks = 0;

  econet_tx dut (
    .econet_clk      (econet_clk),
    .reset           (reset),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_last         (tx_last),
    .tx_ready        (tx_ready),
    .line_busy       (line_busy),
    .econet_data_out (econet_data_out),
    .tx_en           (tx_en),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done),
    .tx_underrun     (tx_underrun)
  );

  initial econet_clk = 1'b0;
  always #5 econet_clk = ~econet_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First character of the string is the first bit on the line (bit 0).
  function automatic logic [63:0] bits_of(input string s);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < s.len() && i < 64; i++) begin
      if (s[i] == 8'h31) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Called just after a rising edge; the byte is taken on a falling edge.
  task automatic push(input logic [7:0] d, input logic l);
    int k;
    k = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && k < 400) begin
      @(posedge econet_clk);
      k++;
    end
    if (!tx_ready) check("push ready timeout", 64'd0, 64'd1);
    @(posedge econet_clk);
    tx_valid = 1'b0;
  endtask

  task automatic capture(output logic [63:0] bits, output int n, output int lat,
                         output int dones, output int unders);
    bit seen;
    seen = 1'b0;
    bits = 64'd0; n = 0; lat = 0; dones = 0; unders = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge econet_clk);
      if (tx_done) dones++;
      if (tx_underrun) unders++;
      if (tx_en) begin
        if (n < 64) bits[n] = econet_data_out;
        n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end else begin
        lat++;
      end
    end
    if (!seen) check("frame start timeout", 64'd0, 64'd1);
  endtask

  logic [63:0] bits;
  int n, lat, dn, un;
  bit any_en;
  string F;

  initial begin
    F         = "01111110";
    reset     = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    line_busy = 1'b0;
    repeat (3) @(posedge econet_clk);
    check("rst data_out", 64'(econet_data_out), 64'd1);
    check("rst tx_en", 64'(tx_en), 64'd0);
    check("rst tx_ready", 64'(tx_ready), 64'd1);
    check("rst tx_busy", 64'(tx_busy), 64'd0);
    check("rst tx_done", 64'(tx_done), 64'd0);
    check("rst tx_underrun", 64'(tx_underrun), 64'd0);
    reset = 1'b0;

    // Single 0x00 byte: accepted on first falling edge, start on the next.
    fork
      push(8'h00, 1'b1);
      capture(bits, n, lat, dn, un);
    join
    check("t1 bits", bits, bits_of({F, "00000000", F}));
    check("t1 len", 64'(n), 64'd24);
    check("t1 lat", 64'(lat), 64'd1);
    check("t1 done", 64'(dn), 64'd1);
    check("t1 under", 64'(un), 64'd0);

    // 0xFF: stuff after five 1s, ones=3 at end so no pre-flag stuff.
    fork
      push(8'hFF, 1'b1);
      capture(bits, n, lat, dn, un);
    join
    check("t2 bits", bits, bits_of({F, "111110111", F}));
    check("t2 len", 64'(n), 64'd25);
    check("t2 done", 64'(dn), 64'd1);

    // 0x1F,0xF8: stuff inside byte 1 and a stuffed 0 before the closing flag.
    fork
      begin
        push(8'h1F, 1'b0);
        push(8'hF8, 1'b1);
      end
      capture(bits, n, lat, dn, un);
    join
    check("t3 bits", bits, bits_of({F, "111110000", "00011111", "0", F}));
    check("t3 len", 64'(n), 64'd34);
    check("t3 done", 64'(dn), 64'd1);

    // Second byte withheld: abort of eight 1s, underrun pulse, no done.
    fork
      push(8'hA5, 1'b0);
      capture(bits, n, lat, dn, un);
    join
    check("t4 bits", bits, bits_of({F, "10100101", "11111111"}));
    check("t4 len", 64'(n), 64'd24);
    check("t4 under", 64'(un), 64'd1);
    check("t4 done", 64'(dn), 64'd0);

    // Next frame after the abort honours the idle gap.
    fork
      push(8'h00, 1'b1);
      capture(bits, n, lat, dn, un);
    join
    check("t5 gap>=15", 64'((lat + 1) >= 15), 64'd1);
    check("t5 bits", bits, bits_of({F, "00000000", F}));
    check("t5 done", 64'(dn), 64'd1);

    // line_busy holds off the start; start on the first edge after release.
    line_busy = 1'b1;
    push(8'h81, 1'b1);
    any_en = 1'b0;
    repeat (20) begin
      @(posedge econet_clk);
      if (tx_en) any_en = 1'b1;
    end
    check("busy no tx_en", 64'(any_en), 64'd0);
    check("busy tx_busy", 64'(tx_busy), 64'd1);
    check("busy tx_ready", 64'(tx_ready), 64'd0);
    line_busy = 1'b0;
    capture(bits, n, lat, dn, un);
    check("t6 lat", 64'(lat), 64'd0);
    check("t6 bits", bits, bits_of({F, "10000001", F}));

    // Reset in the middle of data: line released on the same edge.
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    repeat (3) @(posedge econet_clk);
    check("pre-reset tx_en", 64'(tx_en), 64'd1);
    reset = 1'b1;
    @(posedge econet_clk);
    check("mid rst data_out", 64'(econet_data_out), 64'd1);
    check("mid rst tx_en", 64'(tx_en), 64'd0);
    check("mid rst tx_ready", 64'(tx_ready), 64'd1);
    check("mid rst tx_busy", 64'(tx_busy), 64'd0);
    check("mid rst tx_underrun", 64'(tx_underrun), 64'd0);
    reset = 1'b0;
    fork
      push(8'h00, 1'b1);
      capture(bits, n, lat, dn, un);
    join
    check("t7 lat", 64'(lat), 64'd1);
    check("t7 bits", bits, bits_of({F, "00000000", F}));
    check("t7 done", 64'(dn), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
